// File: rtl/pr_pkg.sv
// ----------------------------------------------------------------------------
// pr_pkg
// Shared definitions for the PageRank write-back slice: default datapath
// width, the fixed AXI single-beat constants and the divider state encoding.
// ----------------------------------------------------------------------------
package pr_pkg;

    localparam int INT_W_DEF = 64;

    // Every write is one 8-byte beat.
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [7:0] LEN_1BEAT  = 8'd0;
    localparam logic [1:0] BRESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_BUSY = 2'd1,
        D_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/pr_divider.sv
// ----------------------------------------------------------------------------
// pr_divider
// Unsigned restoring divider, one quotient bit per clock, WIDTH clocks per
// divide. A zero divisor bypasses the iteration and returns the dividend.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_start       load operands (only honoured while o_idle)
//   i_dividend    numerator
//   i_divisor     denominator
//   i_ack         consumer has finished with o_quotient; return to idle
//   o_idle        ready for a new divide
//   o_done        o_quotient valid and held until i_ack
//   o_quotient    result, remainder discarded
// ----------------------------------------------------------------------------
module pr_divider
    import pr_pkg::*;
#(
    parameter int WIDTH = INT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_ack,
    output logic             o_idle,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       r_state;
    div_state_e       w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;

    // The quotient register starts out holding the dividend; its MSB is
    // shifted into the partial remainder while quotient bits enter at the LSB.
    assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
    assign w_borrow = w_trial[WIDTH];

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= D_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: the next-state default is assigned before the case so that no
    // path through this block leaves w_next unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            D_IDLE: if (i_start) w_next = (i_divisor == '0) ? D_DONE : D_BUSY;
            D_BUSY: if (r_cnt == CW'(WIDTH - 1)) w_next = D_DONE;
            D_DONE: if (i_ack) w_next = D_IDLE;
            default: w_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else begin
            case (r_state)
                D_IDLE: begin
                    if (i_start) begin
                        r_quo <= i_dividend;
                        r_div <= i_divisor;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                D_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    r_rem <= w_borrow ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                end
                default: ;
            endcase
        end
    end

    assign o_idle     = (r_state == D_IDLE);
    assign o_done     = (r_state == D_DONE);
    assign o_quotient = r_quo;

endmodule

// File: rtl/pr_writeback.sv
// ----------------------------------------------------------------------------
// pr_writeback
// Final stage of the PageRank accumulator. Takes one finished vertex at a
// time, divides its rank sum by its out-edge count and writes the 64-bit
// quotient to base_waddr + vid*8 with a single-beat AXI write. Counts B
// responses per round and flags completion and bus errors.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   base_waddr                    output array base, sampled on accept
//   n_expected, clear             round size, latched by the clear pulse
//   in_valid/in_ready             vertex handshake
//   in_vid, in_sum, in_nout       vertex id, rank sum, out-edge count
//   aw*_m, w*_m, b*_m             AXI write master channels
//   n_written                     B responses seen this round
//   round_done                    sticky, n_written reached n_expected
//   err                           sticky, a response had bad bresp or bid
// ----------------------------------------------------------------------------
module pr_writeback
    import pr_pkg::*;
#(
    parameter int          INT_W   = INT_W_DEF,
    parameter int          MAX_OUT = 4,
    parameter logic [15:0] AXI_ID  = 16'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      base_waddr,
    input  logic [63:0]      n_expected,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_vid,
    input  logic [INT_W-1:0] in_sum,
    input  logic [INT_W-1:0] in_nout,
    output logic [15:0]      awid_m,
    output logic [63:0]      awaddr_m,
    output logic [7:0]       awlen_m,
    output logic [2:0]       awsize_m,
    output logic             awvalid_m,
    input  logic             awready_m,
    output logic [15:0]      wid_m,
    output logic [511:0]     wdata_m,
    output logic [63:0]      wstrb_m,
    output logic             wlast_m,
    output logic             wvalid_m,
    input  logic             wready_m,
    input  logic [15:0]      bid_m,
    input  logic [1:0]       bresp_m,
    input  logic             bvalid_m,
    output logic             bready_m,
    output logic [63:0]      n_written,
    output logic             round_done,
    output logic             err
);

    localparam int OW = $clog2(MAX_OUT + 1);

    logic             w_div_idle;
    logic             w_div_done;
    logic [INT_W-1:0] w_quo;
    logic             w_start;
    logic             w_take;
    logic             w_release;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_b_bad;
    logic             w_b_dec;

    logic [63:0]      r_addr;
    logic             r_aw_pend;
    logic             r_w_pend;
    logic [OW-1:0]    r_out;
    logic [63:0]      r_nw;
    logic [63:0]      r_n_exp;
    logic             r_done;
    logic             r_err;

    // The divider's D_DONE state doubles as the single result slot: it holds
    // the quotient (and r_addr holds the address) until both AXI handshakes
    // have completed, so a new vertex is only accepted once the slot frees.
    assign in_ready = w_div_idle;
    assign w_start  = in_valid & w_div_idle;

    pr_divider #(.WIDTH(INT_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (in_sum),
        .i_divisor  (in_nout),
        .i_ack      (w_release),
        .o_idle     (w_div_idle),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    always_ff @(posedge clk) begin
        if (rst)          r_addr <= '0;
        else if (w_start) r_addr <= base_waddr + (64'(in_vid) << 3);
    end

    assign w_aw_hs = awvalid_m & awready_m;
    assign w_w_hs  = wvalid_m & wready_m;
    assign w_b_hs  = bvalid_m & bready_m;
    assign w_b_bad = (bresp_m != BRESP_OKAY) || (bid_m != AXI_ID);
    assign w_b_dec = w_b_hs & (r_out != '0);

    // Take a finished result when neither channel is busy; release the slot
    // on the edge where the last outstanding handshake completes.
    assign w_take    = w_div_done & ~r_aw_pend & ~r_w_pend;
    assign w_release = w_div_done & (r_aw_pend | r_w_pend)
                     & (~r_aw_pend | w_aw_hs) & (~r_w_pend | w_w_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else if (w_take) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
        end else begin
            if (w_aw_hs) r_aw_pend <= 1'b0;
            if (w_w_hs)  r_w_pend  <= 1'b0;
        end
    end

    // While AW is pending r_out can only fall, so a gated awvalid_m never
    // drops once it has risen.
    assign awvalid_m = r_aw_pend & (r_out != OW'(MAX_OUT));
    assign wvalid_m  = r_w_pend;

    always_ff @(posedge clk) begin
        if (rst)                      r_out <= '0;
        else if (w_aw_hs && !w_b_dec) r_out <= r_out + OW'(1);
        else if (!w_aw_hs && w_b_dec) r_out <= r_out - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nw    <= '0;
            r_n_exp <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (clear) begin
            // A response landing with clear belongs to the new round.
            r_nw    <= {63'd0, w_b_hs};
            r_err   <= w_b_hs & w_b_bad;
            r_done  <= 1'b0;
            r_n_exp <= n_expected;
        end else begin
            if (w_b_hs)           r_nw   <= r_nw + 64'd1;
            if (w_b_hs & w_b_bad) r_err  <= 1'b1;
            if ((r_nw == r_n_exp) && (r_n_exp != '0)) r_done <= 1'b1;
        end
    end

    assign awid_m     = AXI_ID;
    assign awaddr_m   = r_addr;
    assign awlen_m    = LEN_1BEAT;
    assign awsize_m   = SIZE_8B;
    assign wid_m      = AXI_ID;
    assign wdata_m    = {8{64'(w_quo)}};
    assign wstrb_m    = 64'hFF << {r_addr[5:3], 3'b000};
    assign wlast_m    = 1'b1;
    assign bready_m   = 1'b1;
    assign n_written  = r_nw;
    assign round_done = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_pr_writeback.sv
// ----------------------------------------------------------------------------
// tb_pr_writeback
// Directed bench for pr_writeback. A queue model predicts address, data and
// strobes for each accepted vertex; round counters are modelled per cycle.
// ----------------------------------------------------------------------------
module tb_pr_writeback;

    localparam int INT_W   = 64;
    localparam int MAX_OUT = 4;

    logic         clk;
    logic         rst;
    logic [63:0]  base_waddr;
    logic [63:0]  n_expected;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_vid;
    logic [63:0]  in_sum;
    logic [63:0]  in_nout;
    logic [15:0]  awid_m;
    logic [63:0]  awaddr_m;
    logic [7:0]   awlen_m;
    logic [2:0]   awsize_m;
    logic         awvalid_m;
    logic         awready_m;
    logic [15:0]  wid_m;
    logic [511:0] wdata_m;
    logic [63:0]  wstrb_m;
    logic         wlast_m;
    logic         wvalid_m;
    logic         wready_m;
    logic [15:0]  bid_m;
    logic [1:0]   bresp_m;
    logic         bvalid_m;
    logic         bready_m;
    logic [63:0]  n_written;
    logic         round_done;
    logic         err;

    pr_writeback #(.INT_W(INT_W), .MAX_OUT(MAX_OUT), .AXI_ID(16'd0)) dut (
        .clk(clk), .rst(rst), .base_waddr(base_waddr), .n_expected(n_expected),
        .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_vid(in_vid),
        .in_sum(in_sum), .in_nout(in_nout), .awid_m(awid_m), .awaddr_m(awaddr_m),
        .awlen_m(awlen_m), .awsize_m(awsize_m), .awvalid_m(awvalid_m),
        .awready_m(awready_m), .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m),
        .wlast_m(wlast_m), .wvalid_m(wvalid_m), .wready_m(wready_m), .bid_m(bid_m),
        .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .n_written(n_written), .round_done(round_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] quo;
    } vtx_t;

    vtx_t        aw_q[$];
    vtx_t        w_q[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_lat = -1;
    logic        prev_awv = 1'b0;
    int          aw_cnt = 0;
    int          w_cnt = 0;
    int          b_cnt = 0;
    int          m_out = 0;
    logic [63:0] m_nw = '0;
    logic [63:0] m_nexp = '0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [63:0] last_awaddr;
    logic [511:0] last_wdata;
    logic [63:0] last_wstrb;

    logic        b_en = 1'b0;
    int          bad_idx = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            aw_q.delete();
            w_q.delete();
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; m_out = 0;
            m_nw = '0; m_nexp = '0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            logic aw_hs, w_hs, b_hs, bad, done_nxt;
            vtx_t v;
            aw_hs = awvalid_m & awready_m;
            w_hs  = wvalid_m & wready_m;
            b_hs  = bvalid_m & bready_m;
            bad   = (bresp_m != 2'b00) || (bid_m != 16'd0);

            check("n_written", n_written, m_nw);
            check("round_done", round_done, m_done);
            check("err", err, m_err);
            check("aw_gate", awvalid_m && (m_out == MAX_OUT), 1'b0);

            if (awvalid_m && !prev_awv) last_lat = cyc - acc_cyc;

            if (in_valid && in_ready) begin
                v.addr = base_waddr + in_vid * 64'd8;
                v.quo  = (in_nout == 0) ? in_sum : in_sum / in_nout;
                aw_q.push_back(v);
                w_q.push_back(v);
                acc_cyc = cyc;
            end
            if (aw_hs) begin
                check("aw_expected", aw_q.size() > 0, 1'b1);
                if (aw_q.size() > 0) begin
                    v = aw_q.pop_front();
                    check("awaddr", awaddr_m, v.addr);
                end
                last_awaddr = awaddr_m;
                aw_cnt++;
            end
            if (w_hs) begin
                check("w_expected", w_q.size() > 0, 1'b1);
                if (w_q.size() > 0) begin
                    v = w_q.pop_front();
                    check("wdata", wdata_m, {8{v.quo}});
                    check("wstrb", wstrb_m, 64'hFF << (8 * int'(v.addr[5:3])));
                end
                last_wdata = wdata_m;
                last_wstrb = wstrb_m;
                w_cnt++;
            end
            if (b_hs) b_cnt++;

            if (aw_hs && !(b_hs && m_out > 0)) m_out++;
            else if (!aw_hs && b_hs && m_out > 0) m_out--;

            done_nxt = m_done | ((m_nw == m_nexp) && (m_nexp != 0));
            if (clear) begin
                m_nw   = b_hs ? 64'd1 : 64'd0;
                m_err  = b_hs & bad;
                m_done = 1'b0;
                m_nexp = n_expected;
            end else begin
                if (b_hs) m_nw = m_nw + 64'd1;
                if (b_hs && bad) m_err = 1'b1;
                m_done = done_nxt;
            end
        end
        prev_awv = awvalid_m;
    end

    // B responder: one response per completed AW+W pair.
    always @(posedge clk) begin
        #1;
        if (!rst && b_en && (((aw_cnt < w_cnt) ? aw_cnt : w_cnt) > b_cnt)) begin
            bvalid_m = 1'b1;
            bresp_m  = (b_cnt == bad_idx) ? 2'b10 : 2'b00;
        end else begin
            bvalid_m = 1'b0;
            bresp_m  = 2'b00;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(input logic [63:0] nexp);
        n_expected = nexp;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic send(input logic [63:0] vid, input logic [63:0] sum,
                        input logic [63:0] nout, input logic [63:0] base);
        base_waddr = base;
        in_vid     = vid;
        in_sum     = sum;
        in_nout    = nout;
        in_valid   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
        end
        check("send_accept", in_ready, 1'b1);
        in_valid = 1'b0;
        tick();
    endtask

    task automatic wait_written(input logic [63:0] n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_written == n) break;
        end
        check("wait_written", n_written, n);
        tick();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int ac0, wc0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; base_waddr = '0;
        n_expected = '0; in_vid = '0; in_sum = '0; in_nout = '0;
        awready_m = 1'b1; wready_m = 1'b1; bid_m = 16'd0;
        bresp_m = 2'b00; bvalid_m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_awvalid", awvalid_m, 1'b0);
        check("rst_wvalid", wvalid_m, 1'b0);
        check("rst_bready", bready_m, 1'b1);
        check("rst_n_written", n_written, 64'd0);
        check("rst_awid_wid", {awid_m, wid_m}, 32'd0);
        check("rst_awlen", awlen_m, 8'd0);
        check("rst_awsize", awsize_m, 3'b011);
        check("rst_wlast", wlast_m, 1'b1);
        tick();
        rst = 1'b0;
        b_en = 1'b1;

        // 1: single vertex, fully ready bus
        pulse_clear(64'd1);
        send(64'd5, 64'd100, 64'd7, 64'h1000);
        wait_written(64'd1, 200);
        check("t1_awaddr", last_awaddr, 64'h1028);
        check("t1_wdata", last_wdata, {8{64'd14}});
        check("t1_wstrb", last_wstrb, 64'h0000FF0000000000);
        check("t1_latency", last_lat, INT_W + 2);
        @(negedge clk);
        check("t1_round_done", round_done, 1'b1);
        tick();

        // 2: dangling vertex bypasses the divide
        pulse_clear(64'd1);
        send(64'd9, 64'd42, 64'd0, 64'h1000);
        wait_written(64'd1, 50);
        check("t2_awaddr", last_awaddr, 64'h1048);
        check("t2_wdata", last_wdata, {8{64'd42}});
        check("t2_wstrb", last_wstrb, 64'h000000000000FF00);
        check("t2_latency", last_lat, 2);

        // 3: AW held off, W completes first
        awready_m = 1'b0;
        pulse_clear(64'd1);
        ac0 = aw_cnt; wc0 = w_cnt;
        send(64'd2, 64'd1000, 64'd10, 64'h2000);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (w_cnt != wc0) break;
        end
        check("t3_w_first", w_cnt - wc0, 1);
        check("t3_aw_pending", aw_cnt - ac0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_in_ready", in_ready, 1'b0);
            check("t3_awvalid", awvalid_m, 1'b1);
            check("t3_awaddr_stable", awaddr_m, 64'h2010);
            check("t3_wvalid", wvalid_m, 1'b0);
        end
        tick();
        awready_m = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_slot_free", in_ready, 1'b1);
        check("t3_aw_drop", awvalid_m, 1'b0);
        tick();
        wait_written(64'd1, 50);
        check("t3_wdata", last_wdata, {8{64'd100}});
        check("t3_wstrb", last_wstrb, 64'h0000000000FF0000);

        // 4: eight vertices with B withheld
        pulse_clear(64'd8);
        b_en = 1'b0;
        ac0 = aw_cnt; wc0 = w_cnt;
        send(64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h4000);
        send(64'd11, 64'd7, 64'd9, 64'h4000);
        send(64'd1, 64'd123456789, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8);
        send(64'd13, 64'd77, 64'd0, 64'h4000);
        send(64'd14, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0001, 64'h4000);
        repeat (100) @(negedge clk);
        check("t4_aw_count", aw_cnt - ac0, 4);
        check("t4_w_count", w_cnt - wc0, 5);
        check("t4_aw_held", awvalid_m, 1'b0);
        check("t4_in_ready", in_ready, 1'b0);
        tick();
        b_en = 1'b1;
        send(64'd15, 64'd1_000_000, 64'd999, 64'h4000);
        send(64'd16, 64'd0, 64'd5, 64'h4000);
        send(64'd17, 64'hDEAD_BEEF_0000_0001, 64'd16, 64'h4000);
        wait_written(64'd8, 800);
        @(negedge clk);
        check("t4_round_done", round_done, 1'b1);
        tick();

        // 5: bad response mid-round, then clear
        pulse_clear(64'd3);
        bad_idx = b_cnt + 1;
        send(64'd20, 64'd30, 64'd0, 64'h5000);
        send(64'd21, 64'd31, 64'd0, 64'h5000);
        send(64'd22, 64'd32, 64'd0, 64'h5000);
        wait_written(64'd3, 50);
        @(negedge clk);
        check("t5_round_done", round_done, 1'b1);
        check("t5_err", err, 1'b1);
        tick();
        bad_idx = -1;
        pulse_clear(64'd3);
        @(negedge clk);
        check("t5_clr_done", round_done, 1'b0);
        check("t5_clr_err", err, 1'b0);
        check("t5_clr_nw", n_written, 64'd0);
        tick();

        // 6: reset during a divide
        pulse_clear(64'd5);
        send(64'd1, 64'd64, 64'd8, 64'h3000);
        wait_written(64'd1, 100);
        send(64'd3, 64'd1000, 64'd3, 64'h3000);
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_awvalid", awvalid_m, 1'b0);
        check("t6_wvalid", wvalid_m, 1'b0);
        check("t6_nw", n_written, 64'd0);
        tick();
        pulse_clear(64'd1);
        send(64'd4, 64'd81, 64'd9, 64'h3000);
        wait_written(64'd1, 100);
        check("t6_awaddr", last_awaddr, 64'h3020);
        check("t6_wdata", last_wdata, {8{64'd9}});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
